// File: rtl/id_branch_resolve_if.sv
// ============================================================================
// Module   : id_branch_resolve_if
// Function : fetch <-> decode link: {IR, nPC} forward, {PCSrc, BrDest} back
// Revision : 1.0
// ============================================================================
`default_nettype none

interface id_branch_resolve_if;
   logic [31:0] IR;
   logic [31:0] nPC;
   logic        PCSrc;
   logic [31:0] BrDest;

   modport master (output IR, output nPC, input PCSrc, input BrDest);
   modport slave  (input IR, input nPC, output PCSrc, output BrDest);
endinterface

`default_nettype wire

// File: rtl/id_branch_resolve.sv
// ============================================================================
// Module   : id_branch_resolve
// Function : IF/ID register, branch/jump resolve and wrong-path squash FSM.
//            Optional macro BRANCH_DELAY_SLOT_EN keeps the first post-redirect word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_branch_resolve #(
   parameter int          FLUSH_SLOTS = 1,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input  wire logic             clk,
   input  wire logic             reset,
   id_branch_resolve_if.slave    fetch,
   input  wire logic             stall,
   input  wire logic [31:0]      rs_data,
   input  wire logic [31:0]      rt_data,
   output logic [31:0]           id_IR,
   output logic [31:0]           id_nPC,
   output logic                  id_valid,
   output logic [15:0]           redirect_cnt
);

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic KEEP_FIRST = 1'b1;
`else
   localparam logic KEEP_FIRST = 1'b0;
`endif

   // The redirect edge itself captures the first wrong-path word; the
   // SQUASH state covers the remaining FLUSH_SLOTS-1 of them.
   localparam logic [1:0] SQ_LOAD = 2'(FLUSH_SLOTS - 1);

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  squash_cnt_q, squash_cnt_d;
   logic [31:0] id_ir_q, id_ir_d;
   logic [31:0] id_npc_q, id_npc_d;
   logic        id_valid_q, id_valid_d;
   logic [15:0] redirect_cnt_q, redirect_cnt_d;

   logic [5:0]  opcode;
   logic        is_branch;
   logic        is_jump;
   logic        taken;
   logic [31:0] br_offset;
   logic [31:0] br_dest;
   logic        pc_src;

   always_comb begin
      opcode    = id_ir_q[31:26];
      is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
      is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
      taken     = ((opcode == OP_BEQ) && (rs_data == rt_data)) ||
                  ((opcode == OP_BNE) && (rs_data != rt_data)) ||
                  is_jump;
      br_offset = is_branch ? {{16{id_ir_q[15]}}, id_ir_q[15:0]} : 32'd0;
      if (is_jump) begin
         br_dest = {id_npc_q[31:26], id_ir_q[25:0]};
      end else begin
         br_dest = id_npc_q + br_offset;
      end
      pc_src = taken & id_valid_q & ~stall & (state_q == RUN) & ~reset;
   end

   assign fetch.PCSrc  = pc_src;
   assign fetch.BrDest = reset ? 32'd0 : br_dest;

   always_comb begin
      state_d        = state_q;
      squash_cnt_d   = squash_cnt_q;
      id_ir_d        = id_ir_q;
      id_npc_d       = id_npc_q;
      id_valid_d     = id_valid_q;
      redirect_cnt_d = redirect_cnt_q;
      if (!stall) begin
         id_npc_d   = fetch.nPC;
         id_ir_d    = fetch.IR;
         id_valid_d = 1'b1;
         if (state_q == SQUASH) begin
            // Branches sitting in squashed slots never reach resolve.
            id_ir_d      = NOP_WORD;
            id_valid_d   = 1'b0;
            squash_cnt_d = squash_cnt_q - 2'd1;
            if (squash_cnt_q == 2'd1) begin
               state_d = RUN;
            end
         end else if (pc_src) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
            if (!KEEP_FIRST) begin
               id_ir_d    = NOP_WORD;
               id_valid_d = 1'b0;
            end
            if (SQ_LOAD != 2'd0) begin
               state_d      = SQUASH;
               squash_cnt_d = SQ_LOAD;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         squash_cnt_q   <= 2'd0;
         id_ir_q        <= NOP_WORD;
         id_npc_q       <= 32'd0;
         id_valid_q     <= 1'b0;
         redirect_cnt_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         squash_cnt_q   <= squash_cnt_d;
         id_ir_q        <= id_ir_d;
         id_npc_q       <= id_npc_d;
         id_valid_q     <= id_valid_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign id_IR        = id_ir_q;
   assign id_nPC       = id_npc_q;
   assign id_valid     = id_valid_q;
   assign redirect_cnt = redirect_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_branch_resolve.sv
// ============================================================================
// Module   : tb_id_branch_resolve
// Function : two instances (FLUSH_SLOTS=1 and 2) against a behavioural model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_branch_resolve;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DELAY = 1'b1;
`else
   localparam bit DELAY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] rs_data, rt_data, IR, nPC;

   always #5 clk = ~clk;

   id_branch_resolve_if f0 ();
   id_branch_resolve_if f1 ();
   assign f0.IR  = IR;
   assign f0.nPC = nPC;
   assign f1.IR  = IR;
   assign f1.nPC = nPC;

   logic [31:0] o_ir [2];
   logic [31:0] o_npc [2];
   logic        o_valid [2];
   logic [15:0] o_red [2];
   logic        o_pcs [2];
   logic [31:0] o_dest [2];
   assign o_pcs[0]  = f0.PCSrc;
   assign o_pcs[1]  = f1.PCSrc;
   assign o_dest[0] = f0.BrDest;
   assign o_dest[1] = f1.BrDest;

   id_branch_resolve #(.FLUSH_SLOTS(1)) u_dut0 (
      .clk(clk), .reset(reset), .fetch(f0), .stall(stall),
      .rs_data(rs_data), .rt_data(rt_data),
      .id_IR(o_ir[0]), .id_nPC(o_npc[0]), .id_valid(o_valid[0]), .redirect_cnt(o_red[0])
   );

   id_branch_resolve #(.FLUSH_SLOTS(2)) u_dut1 (
      .clk(clk), .reset(reset), .fetch(f1), .stall(stall),
      .rs_data(rs_data), .rt_data(rt_data),
      .id_IR(o_ir[1]), .id_nPC(o_npc[1]), .id_valid(o_valid[1]), .redirect_cnt(o_red[1])
   );

   // Reference model: each redirect makes the next FLUSH captures wrong-path.
   int          fl [2] = '{1, 2};
   logic [31:0] m_ir [2];
   logic [31:0] m_npc [2];
   bit          m_valid [2];
   int          m_pend [2];
   logic [15:0] m_red [2];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic bit m_taken(input int k);
      case (m_ir[k][31:26])
         6'h04:        return rs_data == rt_data;
         6'h05:        return rs_data != rt_data;
         6'h02, 6'h03: return 1'b1;
         default:      return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_dest(input int k);
      logic [15:0] imm;
      imm = m_ir[k][15:0];
      if (reset) return 32'd0;
      case (m_ir[k][31:26])
         6'h04, 6'h05: return m_npc[k] + 32'($signed(imm));
         6'h02, 6'h03: return {m_npc[k][31:26], m_ir[k][25:0]};
         default:      return m_npc[k];
      endcase
   endfunction

   function automatic bit m_pcsrc(input int k);
      return !reset && m_taken(k) && m_valid[k] && !stall && (m_pend[k] == 0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ir[k] = 32'd0; m_npc[k] = 32'd0; m_valid[k] = 1'b0;
         m_pend[k] = 0; m_red[k] = 16'd0;
      end
   endtask

   task automatic model_update();
      bit p, kill;
      if (reset || stall) return;
      for (int k = 0; k < 2; k++) begin
         p    = m_pcsrc(k);
         kill = 1'b0;
         if (p) begin
            m_red[k]++;
            m_pend[k] = fl[k];
         end
         if (m_pend[k] > 0) begin
            kill = !(DELAY && (fl[k] - m_pend[k] == 0));
            m_pend[k]--;
         end
         m_ir[k]    = kill ? 32'd0 : IR;
         m_valid[k] = !kill;
         m_npc[k]   = nPC;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("id_IR%0d", k),    o_ir[k],    m_ir[k]);
         check($sformatf("id_nPC%0d", k),   o_npc[k],   m_npc[k]);
         check($sformatf("id_valid%0d", k), 32'(o_valid[k]), 32'(m_valid[k]));
         check($sformatf("red_cnt%0d", k),  32'(o_red[k]),   32'(m_red[k]));
         check($sformatf("PCSrc%0d", k),    32'(o_pcs[k]),   32'(m_pcsrc(k)));
         check($sformatf("BrDest%0d", k),   o_dest[k],  m_dest(k));
      end
   endtask

   // Called in the low clock phase: drive, settle, compare.
   task automatic drive(input logic [31:0] ir, input logic [31:0] npc,
                        input logic [31:0] rs, input logic [31:0] rt, input logic st);
      IR = ir; nPC = npc; rs_data = rs; rt_data = rt; stall = st;
      #1;
      check_all();
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      #1 reset = 1'b1;
      #1 model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [5:0] ops [5] = '{6'h04, 6'h05, 6'h02, 6'h03, 6'h08};

   initial begin
      logic [31:0] r, ir_r, rs_r, rt_r;
      reset = 1'b1; stall = 1'b0; IR = '0; nPC = '0; rs_data = '0; rt_data = '0;
      model_reset();
      @(negedge clk);
      check_all();
      check("rst_PCSrc", 32'(o_pcs[0]), 32'd0);
      check("rst_BrDest", o_dest[0], 32'd0);
      reset = 1'b0;

      // First capture after reset is valid.
      drive(32'h2001_0005, 32'd1, 0, 0, 0); tick();
      check("first_ir", o_ir[0], 32'h2001_0005);
      check("first_valid", 32'(o_valid[0]), 32'd1);

      // BEQ taken.
      drive(32'h1022_0003, 32'h11, 0, 0, 0); tick();
      drive(32'h2003_0007, 32'h12, 5, 5, 0);
      check("beq_pcsrc", 32'(o_pcs[0]), 32'd1);
      check("beq_dest", o_dest[0], 32'h14);
      tick();
      check("beq_slot_valid", 32'(o_valid[0]), 32'(DELAY));
      check("beq_red", 32'(o_red[0]), 32'd1);

      // dut1 is now mid-squash: reset aborts it.
      #2 reset = 1'b1;
      #1 model_reset();
      check("rst_sq_valid", 32'(o_valid[1]), 32'd0);
      check("rst_sq_red", 32'(o_red[1]), 32'd0);
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // BNE: not taken, then taken.
      drive(32'h1422_FFFE, 32'h20, 0, 0, 0); tick();
      drive(32'h0, 32'h21, 7, 7, 0);
      check("bne_nt", 32'(o_pcs[0]), 32'd0);
      drive(32'h0, 32'h21, 7, 8, 0);
      check("bne_t", 32'(o_pcs[0]), 32'd1);
      check("bne_dest", o_dest[0], 32'h1E);
      tick();
      drive(32'h0, 32'h22, 0, 0, 0); tick();
      drive(32'h0, 32'h23, 0, 0, 0); tick();

      // J.
      drive(32'h0800_0040, 32'h0400_0009, 0, 0, 0); tick();
      drive(32'h0, 32'h0400_000A, 0, 0, 0);
      check("j_pcsrc", 32'(o_pcs[0]), 32'd1);
      check("j_dest", o_dest[0], 32'h0400_0040);
      tick();
      drive(32'h0, 32'h41, 0, 0, 0); tick();
      drive(32'h0, 32'h42, 0, 0, 0); tick();

      // Taken BEQ held by stall for 3 cycles.
      drive(32'h1022_0003, 32'h11, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(32'hDEAD_0000 + 32'(i), 32'h50 + 32'(i), 5, 5, 1);
         check("stall_pcsrc", 32'(o_pcs[0]), 32'd0);
         check("stall_ir", o_ir[0], 32'h1022_0003);
         tick();
      end
      drive(32'h0, 32'h12, 5, 5, 0);
      check("unstall_pcsrc", 32'(o_pcs[0]), 32'd1);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 99) < 2) begin
            reset_pulse();
         end else begin
            r    = $urandom();
            ir_r = {ops[$urandom_range(0, 4)], r[25:0]};
            rs_r = $urandom_range(0, 3);
            rt_r = ($urandom_range(0, 1) == 1) ? rs_r : 32'($urandom_range(0, 3));
            drive(ir_r, $urandom(), rs_r, rt_r, ($urandom_range(0, 99) < 20));
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
